// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the data-RAM arbiter slice: FSM state encoding,
//   requester port indices, the default read-timeout and a small helper that
//   turns a port index into a one-hot per-port pulse vector.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    WRITE     = 2'd2,
    READ_WAIT = 2'd3
  } arb_state_t;

  // Requester port indices
  localparam int unsigned PORT_CU  = 0;  // control unit load/store path
  localparam int unsigned PORT_DBG = 1;  // debug/DMA loader

  // Default maximum number of cycles to wait for mem_out_valid
  localparam int unsigned RD_TIMEOUT_DEF = 7;

  // One-hot per-port vector for a winner index (0 = PORT_CU, 1 = PORT_DBG)
  function automatic logic [1:0] port_mask(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way selector used by mem_arbiter's IDLE decision.
//   Default build: round-robin -- on a tie the port NOT granted last wins.
//   With MEM_ARB_FIXED_PRIO_EN defined: PORT_CU always wins a tie and the
//   last-grant input is ignored.
//
// Ports
//   req    in  2  per-port request
//   last   in  1  index of the port granted last
//   valid  out 1  at least one port requests
//   win    out 1  winning port index (0 = PORT_CU, 1 = PORT_DBG)
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       win
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last;

  always_comb begin
    unused_last = last;
    valid       = |req;
    win         = req[PORT_DBG] && !req[PORT_CU];
  end
`else
  always_comb begin
    valid = |req;
    // PORT_DBG wins when it is alone, or on a tie when PORT_CU was granted last
    win   = req[PORT_DBG] && (!req[PORT_CU] || (last == 1'b0));
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter and sequencer for the 16x8 data RAM. Port 0 (PORT_CU)
//   is the control unit's load/store path, port 1 (PORT_DBG) the debug/DMA
//   loader. Also serialises whole-RAM clear requests. All outputs are
//   registered; the block owns every RAM control signal.
//
//   Build option: MEM_ARB_FIXED_PRIO_EN -- when defined, port 0 always wins
//   a tie and no last-grant pointer is kept; otherwise ties alternate.
//
// Parameters
//   ADDR_W      RAM address width (default 4)
//   DATA_W      RAM data width (default 8)
//   RD_TIMEOUT  max cycles waiting for mem_out_valid, legal 1..15 (default 7)
//
// Ports
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   clr_req        in   whole-RAM clear request (level)
//   req[1:0]       in   per-port request (level)
//   we[1:0]        in   per-port write enable (1 write, 0 read)
//   addr           in   per-port address, port i at [i*ADDR_W +: ADDR_W]
//   wdata          in   per-port write data, port i at [i*DATA_W +: DATA_W]
//   gnt[1:0]       out  one-cycle pulse: request accepted
//   done[1:0]      out  one-cycle pulse: transaction completed
//   clr_done       out  one-cycle pulse: clear completed
//   rdata          out  read data, valid with done
//   err            out  read timed out, valid with done
//   busy           out  state is not IDLE
//   mem_rw         out  RAM write strobe (high only in WRITE)
//   mem_clr        out  RAM clear strobe
//   mem_address    out  RAM address
//   mem_data_in    out  RAM write data
//   mem_data_out   in   RAM read data
//   mem_out_valid  in   RAM read data valid
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr_req,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic                clr_done,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                busy,
  output logic                mem_rw,
  output logic                mem_clr,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W-1:0]   mem_data_out,
  input  logic                mem_out_valid
);

  localparam int unsigned      CNT_W = 4;
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(RD_TIMEOUT);

  arb_state_t        state;
  logic              win_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              last_gnt;
  logic              pick_valid;
  logic              pick_win;
  logic              take;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_gnt),
    .valid (pick_valid),
    .win   (pick_win)
  );

  always_comb begin
    take      = (state == IDLE) && !clr_req && pick_valid;
    sel_addr  = pick_win ? addr[ADDR_W +: ADDR_W]   : addr[0 +: ADDR_W];
    sel_wdata = pick_win ? wdata[DATA_W +: DATA_W]  : wdata[0 +: DATA_W];
    sel_we    = pick_win ? we[PORT_DBG]             : we[PORT_CU];
    cnt_nxt   = cnt + CNT_W'(1);
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb last_gnt = 1'b1;
`else
  // Reset to 1 so that PORT_CU wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= 1'b1;
    end else if (take) begin
      last_gnt <= pick_win;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      win_q       <= 1'b0;
      cnt         <= '0;
      gnt         <= '0;
      done        <= '0;
      clr_done    <= 1'b0;
      rdata       <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      mem_rw      <= 1'b0;
      mem_clr     <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      // Pulse outputs default low every cycle
      gnt      <= '0;
      done     <= '0;
      clr_done <= 1'b0;

      case (state)
        IDLE: begin
          if (clr_req) begin
            mem_clr <= 1'b1;
            busy    <= 1'b1;
            state   <= CLEAR;
          end else if (take) begin
            gnt         <= port_mask(pick_win);
            win_q       <= pick_win;
            mem_address <= sel_addr;
            mem_data_in <= sel_wdata;
            cnt         <= '0;
            busy        <= 1'b1;
            if (sel_we) begin
              mem_rw <= 1'b1;
              state  <= WRITE;
            end else begin
              state  <= READ_WAIT;
            end
          end
        end

        CLEAR: begin
          mem_clr  <= 1'b0;
          clr_done <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        WRITE: begin
          mem_rw <= 1'b0;
          done   <= port_mask(win_q);
          err    <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        READ_WAIT: begin
          // Valid data takes precedence over a timeout landing in the same cycle
          if (mem_out_valid) begin
            rdata <= mem_data_out;
            err   <= 1'b0;
            done  <= port_mask(win_q);
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt_nxt == TMO) begin
            rdata <= '0;
            err   <= 1'b1;
            done  <= port_mask(win_q);
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int TMO = 7;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr_req = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] we = '0;
  logic [7:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0] gnt, done;
  logic       clr_done, err, busy, mem_rw, mem_clr;
  logic [7:0] rdata, mem_data_in;
  logic [3:0] mem_address;
  logic [7:0] mem_data_out = 8'hEE;
  logic       mem_out_valid = 1'b0;

  int nchk = 0;
  int nerr = 0;

  mem_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .clr_req(clr_req), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .done(done), .clr_done(clr_done),
    .rdata(rdata), .err(err), .busy(busy), .mem_rw(mem_rw), .mem_clr(mem_clr),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_out_valid(mem_out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nchk++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // ---------------- RAM model and read responder ----------------
  logic [7:0] ram [16];
  int rd_lat = 0;
  int rsp_cnt = 0;
  bit rsp_pend = 0;

  task automatic ram_step();
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    end else if (mem_rw) begin
      ram[mem_address] = mem_data_in;
    end
  endtask

  // rd_lat = number of READ_WAIT cycles with valid low before valid is returned
  task automatic rsp_step();
    if (!reset_n) begin
      rsp_pend = 0;
    end else if (gnt != 2'b00 && !mem_rw) begin
      rsp_pend = 1;
      rsp_cnt  = 0;
    end
    mem_out_valid = 1'b0;
    mem_data_out  = 8'hEE;
    if (rsp_pend) begin
      if (rsp_cnt == rd_lat) begin
        mem_out_valid = 1'b1;
        mem_data_out  = ram[mem_address];
        rsp_pend      = 0;
      end else begin
        rsp_cnt++;
      end
    end
  endtask

  always @(posedge clk) ram_step();
  always @(negedge clk) rsp_step();

  // ---------------- Behavioural reference model ----------------
  // m_kind: 0 nothing in flight, 1 clearing, 2 writing, 3 reading
  int m_kind = 0, m_port = 0, m_age = 0, m_last = 1;
  logic [1:0] e_gnt = '0, e_done = '0;
  logic e_clr_done = 0, e_rw = 0, e_clr = 0, e_err = 0, e_busy = 0, e_rd_done = 0;
  logic [3:0] e_addr = '0;
  logic [7:0] e_wd = '0, e_rdata = '0;

  task automatic model_finish(input bit is_read);
    e_done    = 2'(1 << m_port);
    e_rd_done = is_read;
    m_kind    = 0;
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_kind = 0; m_last = 1; m_age = 0;
      e_gnt = '0; e_done = '0; e_clr_done = 0; e_rw = 0; e_clr = 0;
      e_err = 0; e_busy = 0; e_rd_done = 0; e_addr = '0; e_wd = '0; e_rdata = '0;
    end else begin
      e_gnt = '0; e_done = '0; e_clr_done = 0; e_rd_done = 0;
      case (m_kind)
        0: begin
          if (clr_req) begin
            m_kind = 1; e_clr = 1;
          end else if (req != 2'b00) begin
            if (req == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
              m_port = 0;
`else
              m_port = 1 - m_last;
`endif
            end else begin
              m_port = req[1] ? 1 : 0;
            end
            m_last = m_port;
            e_gnt  = 2'(1 << m_port);
            e_addr = 4'(addr >> (4 * m_port));
            e_wd   = 8'(wdata >> (8 * m_port));
            if (we[m_port]) begin
              m_kind = 2; e_rw = 1;
            end else begin
              m_kind = 3; m_age = 0;
            end
          end
        end
        1: begin
          e_clr = 0; e_clr_done = 1; m_kind = 0;
        end
        2: begin
          e_rw = 0; e_err = 0; model_finish(0);
        end
        default: begin
          m_age++;
          if (mem_out_valid) begin
            e_rdata = mem_data_out; e_err = 0; model_finish(1);
          end else if (m_age == TMO) begin
            e_rdata = 8'h00; e_err = 1; model_finish(1);
          end
        end
      endcase
      e_busy = (m_kind != 0);
    end
  endtask

  always @(posedge clk or negedge reset_n) model_step();

  // ---------------- Per-cycle comparison ----------------
  always @(negedge clk) begin
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("done", 32'(done), 32'(e_done));
    chk("clr_done", 32'(clr_done), 32'(e_clr_done));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("mem_rw", 32'(mem_rw), 32'(e_rw));
    chk("mem_clr", 32'(mem_clr), 32'(e_clr));
    chk("mem_address", 32'(mem_address), 32'(e_addr));
    chk("mem_data_in", 32'(mem_data_in), 32'(e_wd));
    if (e_done != 2'b00) begin
      chk("err", 32'(err), 32'(e_err));
      if (e_rd_done) chk("rdata", 32'(rdata), 32'(e_rdata));
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic wait_done(input int maxc, output int k);
    bit seen = 0;
    k = 0;
    while (k < maxc && !seen) begin
      @(posedge clk); #1;
      k++;
      if (done != 2'b00) seen = 1;
    end
    chk("done_within_bound", 32'(seen), 32'd1);
  endtask

  task automatic set_port(input int p, input logic [3:0] a, input logic [7:0] d, input bit w);
    req   = 2'(1 << p);
    we    = w ? 2'(1 << p) : 2'b00;
    addr  = (p == 1) ? {a, 4'h0} : {4'h0, a};
    wdata = (p == 1) ? {d, 8'h00} : {8'h00, d};
  endtask

  task automatic do_write(input int p, input logic [3:0] a, input logic [7:0] d);
    int k;
    @(negedge clk);
    set_port(p, a, d, 1'b1);
    @(posedge clk); #1;
    chk("wr_gnt", 32'(gnt), 32'(1 << p));
    chk("wr_mem_rw", 32'(mem_rw), 32'd1);
    chk("wr_addr", 32'(mem_address), 32'(a));
    chk("wr_data", 32'(mem_data_in), 32'(d));
    @(negedge clk);
    req = '0; we = '0;
    wait_done(20, k);
    chk("wr_latency", 32'(k), 32'd1);
    chk("wr_done", 32'(done), 32'(1 << p));
    chk("wr_err", 32'(err), 32'd0);
  endtask

  task automatic do_read(input int p, input logic [3:0] a, input int lat,
                         input int exp_k, input logic [7:0] exp_rd, input logic exp_err);
    int k;
    @(negedge clk);
    rd_lat = lat;
    set_port(p, a, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk("rd_gnt", 32'(gnt), 32'(1 << p));
    chk("rd_mem_rw", 32'(mem_rw), 32'd0);
    @(negedge clk);
    req = '0;
    wait_done(30, k);
    chk("rd_latency", 32'(k), 32'(exp_k));
    chk("rd_done", 32'(done), 32'(1 << p));
    chk("rd_rdata", 32'(rdata), 32'(exp_rd));
    chk("rd_err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [1:0] seq [4];
    logic [1:0] exp_seq [4];
    int k, w, ndone;

`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_clr", 32'(mem_clr), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Port 0 write, then port 1 read back with valid after 2 wait cycles
    do_write(0, 4'd4, 8'h5A);
    do_read(1, 4'd4, 2, 3, 8'h5A, 1'b0);

    // Both ports reading continuously
    @(negedge clk);
    rd_lat = 0; req = 2'b11; we = 2'b00; addr = {4'd4, 4'd1}; wdata = '0;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      do begin
        @(posedge clk); #1; w++;
      end while (gnt == 2'b00 && w < 10);
      seq[g] = gnt;
    end
    @(negedge clk);
    req = '0;
    wait_done(10, k);
    for (int g = 0; g < 4; g++) chk("rr_grant_seq", 32'(seq[g]), 32'(exp_seq[g]));

    // Clear and port-0 write in the same cycle: clear first, then the write
    @(negedge clk);
    clr_req = 1'b1; set_port(0, 4'd3, 8'h33, 1'b1);
    @(posedge clk); #1;
    chk("clr_mem_clr", 32'(mem_clr), 32'd1);
    chk("clr_no_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    clr_req = 1'b0;
    @(posedge clk); #1;
    chk("clr_done", 32'(clr_done), 32'd1);
    chk("clr_mem_clr_off", 32'(mem_clr), 32'd0);
    @(posedge clk); #1;
    chk("clr_then_gnt", 32'(gnt), 32'b01);
    chk("clr_then_rw", 32'(mem_rw), 32'd1);
    @(negedge clk);
    req = '0; we = '0;
    wait_done(10, k);
    do_read(0, 4'd4, 1, 2, 8'h00, 1'b0);
    do_read(1, 4'd3, 0, 1, 8'h33, 1'b0);

    // Back-to-back writes: request held through done re-grants 2 cycles later
    @(negedge clk);
    set_port(1, 4'd9, 8'h99, 1'b1);
    @(posedge clk); #1;
    chk("b2b_gnt1", 32'(gnt), 32'b10);
    @(posedge clk); #1;
    chk("b2b_done1", 32'(done), 32'b10);
    @(posedge clk); #1;
    chk("b2b_gnt2", 32'(gnt), 32'b10);
    @(negedge clk);
    req = '0; we = '0;
    wait_done(10, k);

    // Read timeout: valid never arrives
    do_read(0, 4'd7, 1000, TMO, 8'h00, 1'b1);

    // Reset asserted while waiting for read data
    @(negedge clk);
    rd_lat = 1000; set_port(1, 4'd2, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk("abort_gnt", 32'(gnt), 32'b10);
    @(negedge clk);
    req = '0;
    @(posedge clk); @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_rw", 32'(mem_rw), 32'd0);
    chk("abort_gnt0", 32'(gnt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mem_address", 32'(mem_address), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done != 2'b00) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // First tie after reset goes to port 0
    @(negedge clk);
    rd_lat = 0; req = 2'b11; we = 2'b00;
    @(posedge clk); #1;
    chk("post_reset_tie", 32'(gnt), 32'b01);
    @(negedge clk);
    req = '0;
    wait_done(10, k);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the 16×8 data RAM. It shares the single memory instance between two requesters: port 0 is the control unit's load/store path, and port 1 is the debug/DMA loader. It also serialises a whole-memory clear request. The block owns every RAM control signal (`mem_rw`, `mem_clr`, `mem_address`, `mem_data_in`) and returns read data and completion status to whichever requester was granted.

## Interface
Parameters:
- `ADDR_W`, default 4: RAM address width.
- `DATA_W`, default 8: RAM data width.
- `RD_TIMEOUT`, default 7: maximum wait cycles for `mem_out_valid`; legal range 1..15.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  system clock; all state changes on the rising edge.
  - `reset_n`  in  1  asynchronous active-low reset.
- Requester side:
  - `clr_req`  in  1  request a whole-RAM clear; level-sensitive.
  - `req`  in  2  per-port transaction request; level-sensitive.
  - `we`  in  2  per-port write enable: 1 = write, 0 = read.
  - `addr`  in  2*ADDR_W  per-port address; port i uses bits [i*ADDR_W +: ADDR_W].
  - `wdata`  in  2*DATA_W  per-port write data; port i uses bits [i*DATA_W +: DATA_W].
  - `gnt`  out  2  one-cycle pulse: the port's request was accepted.
  - `done`  out  2  one-cycle pulse: the port's transaction completed.
  - `clr_done`  out  1  one-cycle pulse: the clear completed.
  - `rdata`  out  DATA_W  read data; valid only while `done` is high.
  - `err`  out  1  read timed out; valid only while `done` is high.
  - `busy`  out  1  high whenever the state is not IDLE.
- RAM side:
  - `mem_rw`  out  1  1 = write this cycle, 0 = read.
  - `mem_clr`  out  1  clear strobe.
  - `mem_address`  out  ADDR_W  RAM address.
  - `mem_data_in`  out  DATA_W  RAM write data.
  - `mem_data_out`  in  DATA_W  RAM read data.
  - `mem_out_valid`  in  1  RAM read data valid.

## Operation
- States: IDLE, CLEAR, WRITE, READ_WAIT.
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - Every output is 0, including `mem_rw`, `mem_clr`, `gnt`, `done`, `rdata`, `err`, `busy`, `mem_address` and `mem_data_in`.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
- IDLE, decision priority:
  1. `clr_req` → CLEAR.
  2. Otherwise, any `req` → choose a winner w. Latch `addr` and `wdata` of w onto `mem_address` and `mem_data_in`, pulse `gnt[w]`, and update the last-grant pointer. Go to WRITE if `we[w]`=1, else READ_WAIT.
- CLEAR: `mem_clr`=1 for exactly one cycle. Then `clr_done`=1 and return to IDLE.
- WRITE: `mem_rw`=1 for exactly one cycle. Then `mem_rw`=0, `done[w]`=1 and return to IDLE.
- READ_WAIT: `mem_rw` stays 0 and the wait counter increments each cycle.
  - On `mem_out_valid`=1: `rdata`←`mem_data_out`, `done[w]`=1, `err`=0, return to IDLE.
  - If the counter reaches RD_TIMEOUT first: `rdata`=0, `err`=1, `done[w]`=1, return to IDLE.
- Round-robin arbitration: when both ports request, the port that was not granted last wins.
- Requester contract: drop `req` in the cycle after `gnt`. A `req` still high in the `done` cycle is treated as a new request.
- `mem_rw` is never 1 outside WRITE, so an idle RAM is never written.

## Timing
- Request sampled in IDLE at edge T → `gnt` and RAM signals valid at T+1.
- Write: `done` at T+2.
- Read: `done` one cycle after `mem_out_valid` is seen. Worst case is T+1+RD_TIMEOUT.
- The IDLE cycle that carries `done` also samples new requests, so back-to-back writes complete every 2 cycles.
- `clr_req` together with `req`: the clear wins. The pending `req` is served in the IDLE following `clr_done`.
- `clr_req` or `req` arriving mid-transaction is held off until IDLE. It is never dropped while the input stays high.
- `reset_n` low mid-transaction: immediate return to IDLE with all outputs 0. No `done` is issued for the aborted transaction, and the RAM contents are undefined.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: port 0 always wins a tie, and the last-grant pointer is not implemented.
- Undefined: round-robin as described above.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum: IDLE=2'd0, CLEAR=2'd1, WRITE=2'd2, READ_WAIT=2'd3;
  - port index constants `PORT_CU`=0 and `PORT_DBG`=1;
  - the default RD_TIMEOUT.
- One sub-module, `rr_pick2`: combinational 2-way round-robin and fixed-priority selector taking `req` and the last-grant pointer. It contains the `MEM_ARB_FIXED_PRIO_EN` switch.

## Test plan
- Reset, then port 0 write to addr 4, data 8'h5A → `gnt[0]` at T+1, `mem_rw`=1 for one cycle, `done[0]` at T+2, `err`=0.
- Port 1 read of addr 4 with the RAM model returning valid 2 cycles later → `rdata`=8'h5A and `done[1]` one cycle after valid.
- Both ports request reads continuously → grants alternate 0,1,0,1 (or 0,0,0,0 with `MEM_ARB_FIXED_PRIO_EN`).
- `clr_req` and `req[0]` in the same cycle → `mem_clr` pulse, `clr_done`, then `gnt[0]`.
- Read with `mem_out_valid` held 0 and RD_TIMEOUT=7 → `done` with `err`=1 and `rdata`=0 at T+8.
- `reset_n` asserted during READ_WAIT → `busy`, `mem_rw`, `gnt` and `done` read 0 immediately; no `done` after release.
